// File: rtl/bus_rr_arbiter.sv
// Three-master arbiter onto one request/stall slave port: round-robin or fixed
// priority, back-to-back hand-over, master-0 lock and a stall watchdog.
module bus_rr_arbiter #(
    parameter int RR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  m0_dataenable,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wrdata,
    output logic [31:0] m0_rddata,
    output logic        m0_stall,
    input  logic        m0_lock,

    input  logic [3:0]  m1_dataenable,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wrdata,
    output logic [31:0] m1_rddata,
    output logic        m1_stall,

    input  logic [3:0]  m2_dataenable,
    input  logic        m2_rd,
    input  logic        m2_wr,
    input  logic [31:0] m2_address,
    input  logic [31:0] m2_wrdata,
    output logic [31:0] m2_rddata,
    output logic        m2_stall,

    output logic [3:0]  s_dataenable,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_address,
    output logic [31:0] s_wrdata,
    input  logic [31:0] s_rddata,
    input  logic        s_stall,

    output logic [2:0]  grant,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, GNT2} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state, state_n;
    logic [1:0]  ptr, ptr_n;
    logic [15:0] wd_cnt, wd_cnt_n;
    logic [2:0]  rd_v, wr_v, req, others;
    logic [1:0]  g_idx;
    logic        g_req, fire, done;

    assign rd_v = {m2_rd, m1_rd, m0_rd};
    assign wr_v = {m2_wr, m1_wr, m0_wr};
    assign req  = rd_v | wr_v;

    // Round-robin searches upward from the master after 'from'; 'from' itself last.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] from);
        logic [1:0] c1, c2;
        c1 = (from == 2'd2) ? 2'd0 : from + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (RR_EN != 0) begin
            if (r[c1])      pick = c1;
            else if (r[c2]) pick = c2;
            else            pick = from;
        end else begin
            if (r[0])       pick = 2'd0;
            else if (r[1])  pick = 2'd1;
            else            pick = 2'd2;
        end
    endfunction

    function automatic state_t to_state(input logic [1:0] idx);
        case (idx)
            2'd0:    to_state = GNT0;
            2'd1:    to_state = GNT1;
            default: to_state = GNT2;
        endcase
    endfunction

    always_comb begin
        grant = 3'b000;
        g_idx = 2'd0;
        case (state)
            GNT0: begin grant = 3'b001; g_idx = 2'd0; end
            GNT1: begin grant = 3'b010; g_idx = 2'd1; end
            GNT2: begin grant = 3'b100; g_idx = 2'd2; end
            default: ;
        endcase
    end

    assign g_req       = |(req & grant);
    assign fire        = (TIMEOUT_CYCLES != 0) && (|grant) && (wd_cnt == TO_LIMIT);
    assign done        = g_req && (!s_stall || fire);
    assign others      = req & ~grant;
    assign bus_timeout = fire;

    // The completing master still shows its old request at the hand-over edge,
    // so it is masked out of the re-arbitration.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        wd_cnt_n = '0;
        if (state == IDLE) begin
            if (|req)
                state_n = to_state(pick(req, ptr));
        end else if (!g_req) begin
            state_n = IDLE;
        end else if (done) begin
            ptr_n = g_idx;
            if (g_idx == 2'd0 && m0_lock && !fire)
                state_n = GNT0;
            else if (|others)
                state_n = to_state(pick(others, g_idx));
            else
                state_n = IDLE;
        end else begin
            wd_cnt_n = (wd_cnt == 16'hffff) ? wd_cnt : wd_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd2;
            wd_cnt <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            wd_cnt <= wd_cnt_n;
        end
    end

    always_comb begin
        s_dataenable = '0;
        s_rd         = 1'b0;
        s_wr         = 1'b0;
        s_address    = '0;
        s_wrdata     = '0;
        case (state)
            GNT0: begin
                s_dataenable = m0_dataenable;
                s_rd         = m0_rd;
                s_wr         = m0_wr;
                s_address    = m0_address;
                s_wrdata     = m0_wrdata;
            end
            GNT1: begin
                s_dataenable = m1_dataenable;
                s_rd         = m1_rd;
                s_wr         = m1_wr;
                s_address    = m1_address;
                s_wrdata     = m1_wrdata;
            end
            GNT2: begin
                s_dataenable = m2_dataenable;
                s_rd         = m2_rd;
                s_wr         = m2_wr;
                s_address    = m2_address;
                s_wrdata     = m2_wrdata;
            end
            default: ;
        endcase
        if (fire) begin
            s_rd = 1'b0;
            s_wr = 1'b0;
        end
    end

    // A watchdog firing releases the master as if the slave had answered with zero.
    assign m0_stall  = req[0] & (~grant[0] | (s_stall & ~fire));
    assign m1_stall  = req[1] & (~grant[1] | (s_stall & ~fire));
    assign m2_stall  = req[2] & (~grant[2] | (s_stall & ~fire));
    assign m0_rddata = (grant[0] & req[0] & ~fire) ? s_rddata : 32'd0;
    assign m1_rddata = (grant[1] & req[1] & ~fire) ? s_rddata : 32'd0;
    assign m2_rddata = (grant[2] & req[2] & ~fire) ? s_rddata : 32'd0;

endmodule
